// File: rtl/gru_pkg.sv
// Shared types and constants for the GRU gate sequencer: FSM states, MAC opcodes,
// gate encodings and default geometry.
package gru_pkg;

  localparam int unsigned NIn  = 24;
  localparam int unsigned NHid = 24;
  localparam int unsigned WAw  = 11;
  localparam int unsigned BAw  = 7;
  localparam int unsigned VAw  = 5;

  typedef enum logic [2:0] {
    StIdle,
    StBias,
    StInw,
    StRecw,
    StAct,
    StDone
  } state_e;

  localparam logic [1:0] MacOpBias = 2'd0;
  localparam logic [1:0] MacOpIn   = 2'd1;
  localparam logic [1:0] MacOpRec  = 2'd2;

  localparam logic [1:0] GateZ = 2'd0;
  localparam logic [1:0] GateR = 2'd1;
  localparam logic [1:0] GateH = 2'd2;

endpackage

// File: rtl/gru_addr_gen.sv
// Multiplier-free address generator: a running per-neuron base plus a strided weight
// pointer and a beat index, driven by strobes from the sequencer FSM.
module gru_addr_gen
  import gru_pkg::*;
#(
  parameter int unsigned N_HID = NHid,
  parameter int unsigned W_AW  = WAw,
  parameter int unsigned B_AW  = BAw,
  parameter int unsigned V_AW  = VAw
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            step_i,
  input  logic            rewind_i,
  input  logic            next_i,
  output logic [W_AW-1:0] w_addr_o,
  output logic [B_AW-1:0] bias_addr_o,
  output logic [V_AW-1:0] vec_addr_o
);

  // One row of the flattened weight store spans all three gates.
  localparam logic [W_AW-1:0] Stride = W_AW'(3 * N_HID);

  logic [B_AW-1:0] base_q, base_d;
  logic [W_AW-1:0] w_q, w_d;
  logic [V_AW-1:0] k_q, k_d;

  always_comb begin
    base_d = base_q;
    w_d    = w_q;
    k_d    = k_q;
    if (clear_i) begin
      base_d = '0;
      w_d    = '0;
      k_d    = '0;
    end else if (next_i) begin
      // Base runs on across gates, so g*N_HID+n needs no multiply.
      base_d = base_q + B_AW'(1);
      w_d    = W_AW'(base_d);
      k_d    = '0;
    end else if (rewind_i) begin
      w_d = W_AW'(base_q);
      k_d = '0;
    end else if (step_i) begin
      w_d = w_q + Stride;
      k_d = k_q + V_AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q <= '0;
      w_q    <= '0;
      k_q    <= '0;
    end else begin
      base_q <= base_d;
      w_q    <= w_d;
      k_q    <= k_d;
    end
  end

  assign w_addr_o    = w_q;
  assign bias_addr_o = base_q;
  assign vec_addr_o  = k_q;

endmodule

// File: rtl/gru_gate_sequencer.sv
// Sequences one GRU timestep (gates z, r, h~) over a single shared MAC: per neuron a bias
// load, N_IN input beats, N_HID recurrent beats, then an activation handshake.
module gru_gate_sequencer
  import gru_pkg::*;
#(
  parameter int unsigned N_IN  = NIn,
  parameter int unsigned N_HID = NHid,
  parameter int unsigned W_AW  = WAw,
  parameter int unsigned B_AW  = BAw,
  parameter int unsigned V_AW  = VAw
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            mac_valid,
  input  logic            mac_ready,
  output logic [1:0]      mac_op,
  output logic            mac_last,
  output logic [B_AW-1:0] bias_addr,
  output logic [W_AW-1:0] w_addr,
  output logic [V_AW-1:0] vec_addr,
  output logic            rh_sel,
  output logic [1:0]      gate_id,
  output logic [V_AW-1:0] neuron_id,
  output logic            act_start,
  input  logic            act_done
);

  state_e          state_q, state_d;
  logic [1:0]      gate_q, gate_d;
  logic [V_AW-1:0] neuron_q, neuron_d;
  logic            act_first_q, act_first_d;

  logic ag_clear, ag_step, ag_rewind, ag_next;
  logic accept, last_in, last_rec;

  gru_addr_gen #(
    .N_HID (N_HID),
    .W_AW  (W_AW),
    .B_AW  (B_AW),
    .V_AW  (V_AW)
  ) u_addr_gen (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (ag_clear),
    .step_i      (ag_step),
    .rewind_i    (ag_rewind),
    .next_i      (ag_next),
    .w_addr_o    (w_addr),
    .bias_addr_o (bias_addr),
    .vec_addr_o  (vec_addr)
  );

  assign accept   = mac_valid & mac_ready;
  assign last_in  = (vec_addr == V_AW'(N_IN - 1));
  assign last_rec = (vec_addr == V_AW'(N_HID - 1));

  always_comb begin
    state_d     = state_q;
    gate_d      = gate_q;
    neuron_d    = neuron_q;
    act_first_d = 1'b0;
    ag_clear    = 1'b0;
    ag_step     = 1'b0;
    ag_rewind   = 1'b0;
    ag_next     = 1'b0;
    mac_valid   = 1'b0;
    mac_op      = MacOpBias;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StBias;
          gate_d   = GateZ;
          neuron_d = '0;
          ag_clear = 1'b1;
        end
      end
      StBias: begin
        mac_valid = 1'b1;
        if (accept) state_d = StInw;
      end
      StInw: begin
        mac_valid = 1'b1;
        mac_op    = MacOpIn;
        if (accept) begin
          if (last_in) begin
            state_d   = StRecw;
            ag_rewind = 1'b1;
          end else begin
            ag_step = 1'b1;
          end
        end
      end
      StRecw: begin
        mac_valid = 1'b1;
        mac_op    = MacOpRec;
        if (accept) begin
          if (last_rec) begin
            state_d     = StAct;
            act_first_d = 1'b1;
          end else begin
            ag_step = 1'b1;
          end
        end
      end
      StAct: begin
        if (act_done) begin
          if (neuron_q != V_AW'(N_HID - 1)) begin
            neuron_d = neuron_q + V_AW'(1);
            ag_next  = 1'b1;
            state_d  = StBias;
          end else if (gate_q != GateH) begin
            gate_d   = gate_q + 2'd1;
            neuron_d = '0;
            ag_next  = 1'b1;
            state_d  = StBias;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      gate_q      <= GateZ;
      neuron_q    <= '0;
      act_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gate_q      <= gate_d;
      neuron_q    <= neuron_d;
      act_first_q <= act_first_d;
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign mac_last  = (state_q == StRecw) && last_rec;
  // The candidate gate consumes r*h, so every r is final before gate 2 starts.
  assign rh_sel    = (gate_q == GateH);
  assign gate_id   = gate_q;
  assign neuron_id = neuron_q;
  assign act_start = (state_q == StAct) && act_first_q;

endmodule

// File: tb/tb_gru_gate_sequencer.sv
// Bench for gru_gate_sequencer: a queue of expected beats built from the address formulas,
// an activation-unit model, and directed runs with fixed expectations.
module tb_gru_gate_sequencer;

  localparam int NI = 24;
  localparam int NH = 24;
  localparam int NBEATS = 3 * NH * (1 + NI + NH);

  typedef struct {
    int op;
    int w;
    int b;
    int v;
    int last;
    int rh;
    int g;
    int n;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst, start, mac_ready, act_done;
  logic        busy, done, mac_valid, mac_last, rh_sel, act_start;
  logic [1:0]  mac_op, gate_id;
  logic [10:0] w_addr;
  logic [6:0]  bias_addr;
  logic [4:0]  vec_addr, neuron_id;

  logic act_done_m = 1'b0;
  logic act_inj    = 1'b0;
  assign act_done = act_done_m | act_inj;

  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cnt, act_cnt, done_cnt = 0;
  int    act_delay = 0;
  int    act_wait = -1;
  bit    rand_ready = 1'b0;
  bit    cap_en = 1'b0;
  beat_t exp_q[$];
  int    cap_w[NBEATS];
  int    cap_b[NBEATS];
  int    cap_last[NBEATS];
  int    cap_rh[NBEATS];

  gru_gate_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mac_valid (mac_valid),
    .mac_ready (mac_ready),
    .mac_op    (mac_op),
    .mac_last  (mac_last),
    .bias_addr (bias_addr),
    .w_addr    (w_addr),
    .vec_addr  (vec_addr),
    .rh_sel    (rh_sel),
    .gate_id   (gate_id),
    .neuron_id (neuron_id),
    .act_start (act_start),
    .act_done  (act_done)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    mac_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      mac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_queue();
    beat_t e;
    exp_q.delete();
    for (int g = 0; g < 3; g++) begin
      for (int n = 0; n < NH; n++) begin
        e = '{op: 0, w: g * NH + n, b: g * NH + n, v: 0, last: 0, rh: int'(g == 2), g: g, n: n};
        exp_q.push_back(e);
        for (int k = 0; k < NI; k++) begin
          e.op = 1; e.w = k * 3 * NH + g * NH + n; e.v = k;
          exp_q.push_back(e);
        end
        for (int k = 0; k < NH; k++) begin
          e.op = 2; e.w = k * 3 * NH + g * NH + n; e.v = k; e.last = int'(k == NH - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // Compare process plus activation-unit model, evaluated mid-cycle.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        act_wait   = -1;
        act_done_m = 1'b0;
      end else begin
        if (mac_valid) begin
          chk("beat_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            chk("mac_op", mac_op, e.op);
            chk("w_addr", w_addr, e.w);
            chk("bias_addr", bias_addr, e.b);
            if (e.op != 0) chk("vec_addr", vec_addr, e.v);
            chk("mac_last", mac_last, e.last);
            chk("rh_sel", rh_sel, e.rh);
            chk("gate_id", gate_id, e.g);
            chk("neuron_id", neuron_id, e.n);
            if (mac_ready) begin
              if (cap_en && acc_cnt < NBEATS) begin
                cap_w[acc_cnt]    = int'(w_addr);
                cap_b[acc_cnt]    = int'(bias_addr);
                cap_last[acc_cnt] = int'(mac_last);
                cap_rh[acc_cnt]   = int'(rh_sel);
              end
              acc_cnt++;
              void'(exp_q.pop_front());
            end
          end
        end
        if (done) done_cnt++;
        if (act_wait >= 0) begin
          chk("act_start_once", act_start, 0);
          chk("no_beat_in_act", mac_valid, 0);
        end
        act_done_m = 1'b0;
        if (act_start) begin
          act_cnt++;
          act_wait = act_delay;
        end
        if (act_wait == 0) begin
          act_done_m = 1'b1;
          act_wait   = -1;
        end else if (act_wait > 0) begin
          act_wait--;
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_mac_valid"}, mac_valid, 0);
    chk({tag, "_mac_op"}, mac_op, 0);
    chk({tag, "_mac_last"}, mac_last, 0);
    chk({tag, "_bias_addr"}, bias_addr, 0);
    chk({tag, "_w_addr"}, w_addr, 0);
    chk({tag, "_vec_addr"}, vec_addr, 0);
    chk({tag, "_rh_sel"}, rh_sel, 0);
    chk({tag, "_gate_id"}, gate_id, 0);
    chk({tag, "_neuron_id"}, neuron_id, 0);
    chk({tag, "_act_start"}, act_start, 0);
  endtask

  task automatic run_ts(input int delay, input bit rnd, input int exp_cycles, input bit inject);
    int c0;
    int t;
    build_queue();
    acc_cnt    = 0;
    act_cnt    = 0;
    act_delay  = delay;
    rand_ready = rnd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
    chk("busy_after_start", busy, 1);
    if (inject) begin
      t = 0;
      while (!(mac_valid && mac_op == 2'd1) && t < 200) begin
        @(negedge clk);
        t++;
      end
      chk("inw_reached", int'(mac_valid && mac_op == 2'd1), 1);
      act_inj = 1'b1;
      @(negedge clk);
      act_inj = 1'b0;
    end
    t = 0;
    while (done !== 1'b1 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1);
    if (exp_cycles >= 0) chk("done_cycle", cyc - c0, exp_cycles);
    chk("beats_accepted", acc_cnt, NBEATS);
    chk("act_start_pulses", act_cnt, 3 * NH);
    chk("queue_drained", exp_q.size(), 0);
    chk("busy_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_after_done", busy, 0);
    rand_ready = 1'b0;
  endtask

  initial begin
    int t;
    int d0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero-stall run with immediate act_done.
    cap_en = 1'b1;
    run_ts(0, 1'b0, 3600, 1'b0);
    cap_en = 1'b0;
    chk("n0_bias_addr", cap_b[0], 0);
    chk("n0_bias_w", cap_w[0], 0);
    chk("n0_inw_k1", cap_w[2], 72);
    chk("n0_inw_k23", cap_w[24], 1656);
    chk("n0_recw_k0", cap_w[25], 0);
    chk("n0_recw_k23", cap_w[48], 1656);
    chk("n0_last_49th", cap_last[48], 1);
    chk("n0_not_last_48th", cap_last[47], 0);
    chk("n0_rh_sel", cap_rh[0], 0);
    chk("g1_end_rh_sel", cap_rh[2351], 0);
    chk("g2_start_rh_sel", cap_rh[2352], 1);
    chk("g2n23_bias_addr", cap_b[3479], 71);
    chk("g2n23_first_inw", cap_w[3480], 71);
    chk("g2n23_last_w", cap_w[3527], 1727);
    chk("g2n23_last_flag", cap_last[3527], 1);

    // Random back-pressure; the queue enforces both stability and sequence.
    run_ts(0, 1'b1, -1, 1'b0);

    // Slow activation unit plus a stray act_done during INW.
    run_ts(10, 1'b0, 72 * (49 + 11), 1'b1);

    // Abort mid-gate-1, with a start pulse while busy just beforehand.
    build_queue();
    acc_cnt   = 0;
    act_cnt   = 0;
    act_delay = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(gate_id == 2'd1 && neuron_id == 5'd5) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("reached_gate1", gate_id, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ignored_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrun_reset");
    rst = 1'b0;
    exp_q.delete();
    d0 = done_cnt;
    repeat (30) @(negedge clk);
    chk("no_done_after_abort", done_cnt, d0);
    chk("idle_after_abort", busy, 0);
    run_ts(0, 1'b0, 3600, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
